sbox_mask_prng: RTL and testbench



---
 rtl/sbox_mask_prng.sv | 138 +++++++++++++
 tb/tb_sbox_mask_prng.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_mask_prng.sv
// ---------------------------------------------------------------------------
// sbox_mask_prng
//
// Bit-serial LFSR randomness source for the masked S-box. It publishes one
// 26-bit word at a time, split into an 8-bit input mask and an 18-bit PRD.
// A valid/ready handshake paces the words. The LFSR (x^31 + x^28 + 1) is
// seeded one byte at a time from the pins.
//
// The word is built in a shift accumulator. It is copied to the output
// registers only when it is complete, so the S-box never sees a partially
// filled word.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   seed_i       seed byte, shifted into the LFSR on seed_we_i
//   seed_we_i    seed write strobe (any state; restarts the fill)
//   rnd_ready_i  consumer accepts the current word
//   rnd_valid_o  mask_o/prd_o hold a fresh, unconsumed word
//   mask_o       8-bit mask   (word[25:18])
//   prd_o        18-bit PRD   (word[17:0])
//   seeded_o     at least one seed write since reset
//   busy_o       a word is being generated
// ---------------------------------------------------------------------------
module sbox_mask_prng #(
  parameter int LFSR_W = 31,
  parameter int OUT_W  = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       seed_i,
  input  logic             seed_we_i,
  input  logic             rnd_ready_i,
  output logic             rnd_valid_o,
  output logic [7:0]       mask_o,
  output logic [OUT_W-9:0] prd_o,
  output logic             seeded_o,
  output logic             busy_o
);

  localparam int         PRD_W    = OUT_W - 8;
  localparam logic [4:0] LAST_CNT = 5'(OUT_W - 1);

  typedef enum logic [1:0] {
    UNSEEDED = 2'd0,
    FILL     = 2'd1,
    VALID    = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [LFSR_W-1:0]   lfsr_reg, lfsr_next;
  // The oldest accumulator bit would leave the register on the publishing
  // step anyway. Only OUT_W-1 bits are stored; the fresh feedback bit
  // completes the word.
  logic [OUT_W-2:0]    acc_reg, acc_next;
  logic [4:0]          cnt_reg, cnt_next;
  logic [7:0]          mask_reg, mask_next;
  logic [PRD_W-1:0]    prd_reg, prd_next;
  logic                seeded_reg, seeded_next;

  logic                fb;
  logic [OUT_W-1:0]    word;
  logic [LFSR_W-1:0]   seed_shift;

  // x^31 + x^28 + 1
  assign fb         = lfsr_reg[LFSR_W-1] ^ lfsr_reg[LFSR_W-4];
  assign word       = {acc_reg, fb};
  assign seed_shift = {lfsr_reg[LFSR_W-9:0], seed_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= UNSEEDED;
      lfsr_reg   <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      mask_reg   <= '0;
      prd_reg    <= '0;
      seeded_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      lfsr_reg   <= lfsr_next;
      acc_reg    <= acc_next;
      cnt_reg    <= cnt_next;
      mask_reg   <= mask_next;
      prd_reg    <= prd_next;
      seeded_reg <= seeded_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    lfsr_next   = lfsr_reg;
    acc_next    = acc_reg;
    cnt_next    = cnt_reg;
    mask_next   = mask_reg;
    prd_next    = prd_reg;
    seeded_next = seeded_reg;

    if (seed_we_i) begin
      // The seed wins over stepping and publishing. A word pending in VALID
      // is dropped, which also covers a simultaneous transfer. An all-zero
      // state would lock the LFSR, so it is replaced by 1.
      lfsr_next   = (seed_shift == '0) ? LFSR_W'(1) : seed_shift;
      cnt_next    = '0;
      seeded_next = 1'b1;
      state_next  = FILL;
    end else begin
      case (state_reg)
        FILL: begin
          lfsr_next = {lfsr_reg[LFSR_W-2:0], fb};
          acc_next  = word[OUT_W-2:0];
          cnt_next  = cnt_reg + 5'd1;
          if (cnt_reg == LAST_CNT) begin
            mask_next  = word[OUT_W-1:PRD_W];
            prd_next   = word[PRD_W-1:0];
            state_next = VALID;
          end
        end
        VALID: begin
          if (rnd_ready_i) begin
            state_next = FILL;
            cnt_next   = '0;
          end
        end
        default: begin
          // UNSEEDED: wait for a seed; ready is ignored.
        end
      endcase
    end
  end

  assign rnd_valid_o = (state_reg == VALID);
  assign busy_o      = (state_reg == FILL);
  assign seeded_o    = seeded_reg;
  assign mask_o      = mask_reg;
  assign prd_o       = prd_reg;

endmodule

// File: tb/tb_sbox_mask_prng.sv
// ---------------------------------------------------------------------------
// tb_sbox_mask_prng
//
// Self-checking bench for sbox_mask_prng. The reference model treats the
// LFSR as a bit stream. Seeding shifts a byte into the state. A word is the
// next 26 stream bits, MSB first.
// ---------------------------------------------------------------------------
module tb_sbox_mask_prng;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  seed_i = 8'h00;
  logic        seed_we_i = 1'b0;
  logic        rnd_ready_i = 1'b0;
  logic        rnd_valid_o;
  logic [7:0]  mask_o;
  logic [17:0] prd_o;
  logic        seeded_o;
  logic        busy_o;

  int checks = 0;
  int passes = 0;

  logic [30:0] m_lfsr;

  sbox_mask_prng dut (
    .clk         (clk),
    .rst         (rst),
    .seed_i      (seed_i),
    .seed_we_i   (seed_we_i),
    .rnd_ready_i (rnd_ready_i),
    .rnd_valid_o (rnd_valid_o),
    .mask_o      (mask_o),
    .prd_o       (prd_o),
    .seeded_o    (seeded_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void m_seed(input logic [7:0] s);
    logic [30:0] v;
    v = {m_lfsr[22:0], s};
    m_lfsr = (v == 31'd0) ? 31'd1 : v;
  endfunction

  // Next bit of the x^31 + x^28 + 1 sequence.
  function automatic logic m_bit();
    logic b;
    b = m_lfsr[30] ^ m_lfsr[27];
    m_lfsr = {m_lfsr[29:0], b};
    return b;
  endfunction

  function automatic logic [25:0] m_word();
    logic [25:0] w;
    w = '0;
    for (int i = 0; i < 26; i++) w = {w[24:0], m_bit()};
    return w;
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; seed_we_i = 1'b0; rnd_ready_i = 1'b0; seed_i = 8'h00;
    tick(); tick();
    rst = 1'b0;
    m_lfsr = '0;
  endtask

  // Ticks until rnd_valid_o is seen, with ready toggled at random meanwhile
  // (it must be ignored while filling). Leaves ready low.
  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!rnd_valid_o && n < budget) begin
      rnd_ready_i = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    rnd_ready_i = 1'b0;
    if (rnd_valid_o)
      $display("word: mask=%02h prd=%05h after %0d cycles", mask_o, prd_o, n);
  endtask

  task automatic seed_write(input logic [7:0] s);
    seed_i = s; seed_we_i = 1'b1;
    tick();
    seed_we_i = 1'b0;
    m_seed(s);
    $display("seed write 0x%02h", s);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 40; i++) tick();
    checks++; if (rnd_valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", rnd_valid_o); else passes++;
    checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_o); else passes++;
    checks++; if (seeded_o !== 1'b0) $display("FAIL reset_seeded got %b want 0", seeded_o); else passes++;
    checks++; if ({mask_o, prd_o} !== 26'h0) $display("FAIL reset_outputs got %02h/%05h want 00/00000", mask_o, prd_o); else passes++;
  endtask

  // Seed one byte from reset and collect two words with ready high.
  task automatic test_seed(input logic [7:0] s);
    int n;
    logic [25:0] w;
    do_reset();
    seed_write(s);
    checks++; if (busy_o !== 1'b1 || rnd_valid_o !== 1'b0 || seeded_o !== 1'b1)
      $display("FAIL seed_status busy=%b valid=%b seeded=%b want 1/0/1", busy_o, rnd_valid_o, seeded_o); else passes++;
    wait_valid(40, n);
    checks++; if (n !== 26 || rnd_valid_o !== 1'b1) $display("FAIL seed_latency got %0d want 26", n); else passes++;
    w = m_word();
    checks++; if ({mask_o, prd_o} !== w) $display("FAIL seed_word1 got %02h/%05h want %07h", mask_o, prd_o, w); else passes++;
    checks++; if ({mask_o, prd_o} !== 26'h0) $display("FAIL seed_word1_const got %02h/%05h want 00/00000", mask_o, prd_o); else passes++;
    rnd_ready_i = 1'b1;
    tick();
    rnd_ready_i = 1'b0;
    checks++; if (rnd_valid_o !== 1'b0) $display("FAIL transfer_drop got %b want 0", rnd_valid_o); else passes++;
    wait_valid(40, n);
    checks++; if (n !== 26) $display("FAIL word2_latency got %0d want 26", n); else passes++;
    w = m_word();
    checks++; if ({mask_o, prd_o} !== w) $display("FAIL seed_word2 got %02h/%05h want %07h", mask_o, prd_o, w); else passes++;
    checks++; if ({mask_o, prd_o} !== {8'h48, 18'h0}) $display("FAIL seed_word2_const got %02h/%05h want 48/00000", mask_o, prd_o); else passes++;
  endtask

  task automatic test_random();
    int n;
    int d;
    logic [25:0] w;
    do_reset();
    for (int i = 0; i < 4; i++) seed_write(8'($urandom));
    for (int k = 0; k < 6; k++) begin
      wait_valid(40, n);
      checks++; if (n !== 26) $display("FAIL rand_latency word %0d got %0d want 26", k, n); else passes++;
      w = m_word();
      checks++; if ({mask_o, prd_o} !== w) $display("FAIL rand_word %0d got %02h/%05h want %07h", k, mask_o, prd_o, w); else passes++;
      d = $urandom_range(0, 4);
      for (int j = 0; j < d; j++) tick();
      checks++; if (rnd_valid_o !== 1'b1 || {mask_o, prd_o} !== w)
        $display("FAIL rand_hold %0d valid=%b got %02h/%05h want %07h", k, rnd_valid_o, mask_o, prd_o, w); else passes++;
      rnd_ready_i = 1'b1;
      tick();
      rnd_ready_i = 1'b0;
      checks++; if (rnd_valid_o !== 1'b0 || {mask_o, prd_o} !== w)
        $display("FAIL rand_after_xfer %0d valid=%b got %02h/%05h want %07h", k, rnd_valid_o, mask_o, prd_o, w); else passes++;
    end
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    logic [25:0] w;
    do_reset();
    seed_write(8'hC3);
    wait_valid(40, n);
    w = m_word();
    checks++; if ({mask_o, prd_o} !== w) $display("FAIL bp_word1 got %02h/%05h want %07h", mask_o, prd_o, w); else passes++;
    bad = 0;
    rnd_ready_i = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (rnd_valid_o !== 1'b1 || {mask_o, prd_o} !== w) bad++;
    end
    checks++; if (bad != 0) $display("FAIL bp_stable got %0d unstable cycles want 0", bad); else passes++;
    rnd_ready_i = 1'b1;
    tick();
    rnd_ready_i = 1'b0;
    wait_valid(40, n);
    checks++; if (n !== 26) $display("FAIL bp_latency got %0d want 26", n); else passes++;
    w = m_word();  // a frozen LFSR makes this the very next stream word
    checks++; if ({mask_o, prd_o} !== w) $display("FAIL bp_word2 got %02h/%05h want %07h", mask_o, prd_o, w); else passes++;
  endtask

  task automatic test_mid_fill_seed();
    int n;
    logic [25:0] w;
    do_reset();
    seed_write(8'h01);
    for (int i = 0; i < 10; i++) begin
      tick();
      void'(m_bit());
    end
    checks++; if ({mask_o, prd_o} !== 26'h0 || rnd_valid_o !== 1'b0)
      $display("FAIL midfill_outputs got %02h/%05h valid=%b want 00/00000 0", mask_o, prd_o, rnd_valid_o); else passes++;
    seed_write(8'h01);
    wait_valid(40, n);
    checks++; if (n !== 26) $display("FAIL midfill_latency got %0d want 26", n); else passes++;
    w = m_word();
    checks++; if ({mask_o, prd_o} !== w) $display("FAIL midfill_word got %02h/%05h want %07h", mask_o, prd_o, w); else passes++;
  endtask

  task automatic test_seed_in_valid();
    int n;
    logic [25:0] w;
    logic [25:0] old;
    do_reset();
    seed_write(8'h9E);
    wait_valid(40, n);
    old = m_word();
    // Seed write and transfer on the same edge.
    seed_i = 8'h27; seed_we_i = 1'b1; rnd_ready_i = 1'b1;
    tick();
    seed_we_i = 1'b0; rnd_ready_i = 1'b0;
    m_seed(8'h27);
    checks++; if (rnd_valid_o !== 1'b0 || busy_o !== 1'b1 || {mask_o, prd_o} !== old)
      $display("FAIL seedvalid_status valid=%b busy=%b got %02h/%05h want 0/1 %07h", rnd_valid_o, busy_o, mask_o, prd_o, old); else passes++;
    wait_valid(40, n);
    checks++; if (n !== 26) $display("FAIL seedvalid_latency got %0d want 26", n); else passes++;
    w = m_word();
    checks++; if ({mask_o, prd_o} !== w) $display("FAIL seedvalid_word got %02h/%05h want %07h", mask_o, prd_o, w); else passes++;
  endtask

  task automatic test_reset_in_valid();
    int n;
    logic [25:0] w;
    do_reset();
    seed_write(8'h5A);
    wait_valid(40, n);
    rst = 1'b1; seed_we_i = 1'b1; rnd_ready_i = 1'b1; seed_i = 8'hA5;
    tick();
    rst = 1'b0; seed_we_i = 1'b0; rnd_ready_i = 1'b0;
    m_lfsr = '0;
    checks++; if (rnd_valid_o !== 1'b0 || busy_o !== 1'b0 || seeded_o !== 1'b0 || {mask_o, prd_o} !== 26'h0)
      $display("FAIL rstvalid_outputs valid=%b busy=%b seeded=%b got %02h/%05h want all zero",
               rnd_valid_o, busy_o, seeded_o, mask_o, prd_o); else passes++;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (rnd_valid_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL rstvalid_idle valid=%b busy=%b want 0/0", rnd_valid_o, busy_o); else passes++;
    // A cleared LFSR makes the next seed behave as if from a fresh reset.
    seed_write(8'h80);
    wait_valid(40, n);
    w = m_word();
    checks++; if ({mask_o, prd_o} !== w) $display("FAIL rstvalid_reseed got %02h/%05h want %07h", mask_o, prd_o, w); else passes++;
  endtask

  initial begin
    test_reset();
    test_seed(8'h01);
    test_seed(8'h00);
    test_random();
    test_backpressure();
    test_mid_fill_seed();
    test_seed_in_valid();
    test_reset_in_valid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
